// File: rtl/hvsync_receiver_if.sv
// rtl/hvsync_receiver_if.sv - sync pair in, recovered position and lock status out
//
// master: the side driving the sync pair and observing the recovered timing.
// slave : the receiver (hvsync_receiver).
//   hsync_in, vsync_in : active-low sync pair, clk domain
//   hpos, vpos         : recovered pixel / line position
//   display_on         : visible-area flag, valid only while fully locked
//   h_locked, v_locked : line / frame lock status
interface hvsync_receiver_if;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       display_on;
    logic       h_locked;
    logic       v_locked;

    modport master (
        output hsync_in, vsync_in,
        input  hpos, vpos, display_on, h_locked, v_locked
    );

    modport slave (
        input  hsync_in, vsync_in,
        output hpos, vpos, display_on, h_locked, v_locked
    );
endinterface

// File: rtl/hvsync_receiver.sv
// rtl/hvsync_receiver.sv - VGA sync receiver recovering hpos/vpos and lock status
//
// Ports:
//   clk     : pixel clock; the sync inputs are already in this domain
//   reset   : asynchronous, active-high
//   sync_if : hvsync_receiver_if.slave (hsync_in/vsync_in in; hpos, vpos,
//             display_on, h_locked, v_locked out)
module hvsync_receiver #(
    parameter int H_TOTAL    = 800,
    parameter int V_TOTAL    = 525,
    parameter int H_LOAD     = 659,
    parameter int V_LOAD     = 490,
    parameter int LOCK_LINES = 4,
    parameter int H_DISPLAY  = 640,
    parameter int V_DISPLAY  = 480
) (
    input  logic              clk,
    input  logic              reset,
    hvsync_receiver_if.slave  sync_if
);

    localparam logic [9:0] SAT      = 10'd1023;
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRAME  = 10'(V_TOTAL);
    localparam logic [9:0] H_LOAD_V = 10'(H_LOAD);
    localparam logic [9:0] V_LOAD_V = 10'(V_LOAD);
    localparam logic [9:0] H_DISP_V = 10'(H_DISPLAY);
    localparam logic [9:0] V_DISP_V = 10'(V_DISPLAY);
    localparam int         GW       = $clog2(LOCK_LINES + 1);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    logic          h_q, h_p_q, v_q, v_p_q;
    logic          hfall, vfall;
    logic          hwrap;
    logic [9:0]    hpos_q, hpos_d;
    logic [9:0]    vpos_q, vpos_d;
    logic [9:0]    hper_q, hper_d;
    logic [9:0]    vlines_q, vlines_d;
    logic          v_locked_q, v_locked_d;
    state_t        state_q, state_d;
    logic [GW-1:0] good_cnt_q, good_cnt_d, good_cnt_inc;
    logic          h_locked;
    logic          line_good;
    logic          hsync_lost;

    // Two-stage history of each sync input; idle-high reset values mean no
    // edge is seen until the input actually drops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q   <= 1'b1;
            h_p_q <= 1'b1;
            v_q   <= 1'b1;
            v_p_q <= 1'b1;
        end else begin
            h_q   <= sync_if.hsync_in;
            h_p_q <= h_q;
            v_q   <= sync_if.vsync_in;
            v_p_q <= v_q;
        end
    end

    assign hfall = h_p_q & ~h_q;
    assign vfall = v_p_q & ~v_q;

    // A line is good when exactly H_TOTAL clocks separate two hfalls;
    // a saturated period counter means HSync has disappeared.
    assign line_good  = (hper_q == H_LAST);
    assign hsync_lost = (hper_q == SAT);

    always_comb begin
        hwrap  = 1'b0;
        hpos_d = hpos_q + 10'd1;
        if (hfall) begin
            hpos_d = H_LOAD_V;
        end else if (hpos_q == H_LAST) begin
            hpos_d = '0;
            hwrap  = 1'b1;
        end

        // vfall wins over the line advance from a wrap
        vpos_d = vpos_q;
        if (vfall) begin
            vpos_d = V_LOAD_V;
        end else if (hwrap) begin
            vpos_d = (vpos_q == V_LAST) ? 10'd0 : vpos_q + 10'd1;
        end

        hper_d = hfall ? 10'd0 : ((hper_q == SAT) ? SAT : hper_q + 10'd1);

        // An hfall coinciding with vfall belongs to the new frame.
        vlines_d = vlines_q;
        if (vfall) begin
            vlines_d = {9'd0, hfall};
        end else if (hfall && (vlines_q != SAT)) begin
            vlines_d = vlines_q + 10'd1;
        end

        v_locked_d = v_locked_q;
        if (!h_locked || (vlines_q == SAT)) begin
            v_locked_d = 1'b0;
        end else if (vfall) begin
            v_locked_d = (vlines_q == V_FRAME);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q     <= '0;
            vpos_q     <= '0;
            hper_q     <= SAT;
            vlines_q   <= SAT;
            v_locked_q <= 1'b0;
        end else begin
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
            hper_q     <= hper_d;
            vlines_q   <= vlines_d;
            v_locked_q <= v_locked_d;
        end
    end

    // Line-lock FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            good_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
        end
    end

    // Line-lock FSM: next state
    always_comb begin
        state_d      = state_q;
        good_cnt_d   = good_cnt_q;
        good_cnt_inc = good_cnt_q + GW'(1);
        if (hsync_lost) begin
            state_d    = SEARCH;
            good_cnt_d = '0;
        end else if (hfall) begin
            if (state_q == SEARCH) begin
                if (line_good) begin
                    if (good_cnt_inc == GW'(LOCK_LINES)) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_inc;
                    end
                end else begin
                    good_cnt_d = '0;
                end
            end else if (!line_good) begin
                state_d    = SEARCH;
                good_cnt_d = '0;
            end
        end
    end

    // Line-lock FSM: outputs
    always_comb begin
        h_locked = (state_q == LOCKED);
    end

    assign sync_if.hpos       = hpos_q;
    assign sync_if.vpos       = vpos_q;
    assign sync_if.h_locked   = h_locked;
    assign sync_if.v_locked   = v_locked_q;
    assign sync_if.display_on = h_locked & v_locked_q &
                                (hpos_q < H_DISP_V) & (vpos_q < V_DISP_V);

endmodule

// File: tb/tb_hvsync_receiver.sv
// tb/tb_hvsync_receiver.sv - self-checking bench for hvsync_receiver
module tb_hvsync_receiver;

    localparam int HT    = 50;
    localparam int VT    = 20;
    localparam int HD    = 32;
    localparam int VD    = 12;
    localparam int HS    = 36;
    localparam int HE    = 41;
    localparam int VS    = 15;
    localparam int VE    = 16;
    localparam int HL    = HS + 3;
    localparam int VL    = VS;
    localparam int LK    = 4;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hvsync_receiver_if bus ();

    hvsync_receiver #(
        .H_TOTAL(HT), .V_TOTAL(VT), .H_LOAD(HL), .V_LOAD(VL),
        .LOCK_LINES(LK), .H_DISPLAY(HD), .V_DISPLAY(VD)
    ) dut (
        .clk    (clk),
        .reset  (rst),
        .sync_if(bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // sync generator driving the inputs (registered sync outputs)
    int   gh, gv;
    logic g_hs, g_vs;
    bit   skip_pix, skip_line, force_h, force_v, gen_chk;

    // reference model: event times and counts
    int n, last_hl, wraps, vbase, vcnt, streak, e_hpos, e_vpos;
    bit have_hl, pend_h, pend_v, ps_h, ps_v, e_hl, e_vl, e_don;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return 32'({bus.hpos, bus.vpos, bus.display_on, bus.h_locked, bus.v_locked});
    endfunction

    task automatic gen_reset();
        gh = 0; gv = 0; g_hs = 1'b1; g_vs = 1'b1;
        skip_pix = 1'b0; skip_line = 1'b0;
    endtask

    task automatic gen_edge();
        g_hs = !(gh >= HS && gh <= HE);
        g_vs = !(gv >= VS && gv <= VE);
        gh = gh + (skip_pix ? 2 : 1);
        skip_pix = 1'b0;
        if (gh >= HT) begin
            gh = gh - HT;
            gv = gv + (skip_line ? 2 : 1);
            skip_line = 1'b0;
            if (gv >= VT) gv = gv - VT;
        end
    endtask

    task automatic model_reset();
        n = 0; have_hl = 1'b0; last_hl = 0; wraps = 0; vbase = 0; vcnt = 1023;
        streak = 0; pend_h = 1'b0; pend_v = 1'b0; ps_h = 1'b1; ps_v = 1'b1;
        e_hpos = 0; e_vpos = 0; e_hl = 1'b0; e_vl = 1'b0; e_don = 1'b0;
    endtask

    // sh/sv: input levels sampled at this clock edge
    task automatic model_edge(input bit sh, input bit sv);
        int prev_hpos, prev_hper, prev_vcnt;
        bit prev_hl, hl, vl, wrap;
        n++;
        hl = pend_h;
        vl = pend_v;
        prev_hpos = e_hpos;
        prev_hl   = e_hl;
        prev_vcnt = vcnt;
        prev_hper = have_hl ? (((n - 1 - last_hl) > 1023) ? 1023 : (n - 1 - last_hl)) : 1023;
        if (hl) streak = (prev_hper == HT - 1) ? streak + 1 : 0;
        if (prev_hper == 1023) streak = 0;
        e_hl = (streak >= LK);
        if (hl) begin
            have_hl = 1'b1;
            last_hl = n;
        end
        e_hpos = have_hl ? (HL + n - last_hl) % HT : n % HT;
        wrap = !hl && (prev_hpos == HT - 1);
        if (vl) begin
            vbase = VL;
            wraps = 0;
        end else if (wrap) begin
            wraps++;
        end
        e_vpos = (vbase + wraps) % VT;
        if (vl) vcnt = hl ? 1 : 0;
        else if (hl && vcnt < 1023) vcnt++;
        if (!prev_hl || prev_vcnt >= 1023) e_vl = 1'b0;
        else if (vl) e_vl = (prev_vcnt == VT);
        pend_h = ps_h && !sh; ps_h = sh;
        pend_v = ps_v && !sv; ps_v = sv;
        e_don = e_hl && e_vl && (e_hpos < HD) && (e_vpos < VD);
    endtask

    task automatic cyc();
        bit dh, dv, gd;
        dh = force_h ? 1'b1 : g_hs;
        dv = force_v ? 1'b1 : g_vs;
        bus.hsync_in = dh;
        bus.vsync_in = dv;
        @(posedge clk);
        model_edge(dh, dv);
        gen_edge();
        #1;
        check("cyc", outs(), 32'({10'(e_hpos), 10'(e_vpos), e_don, e_hl, e_vl}));
        if (gen_chk) begin
            gd = (gh < HD) && (gv < VD);
            check("gen", 32'({bus.hpos, bus.vpos, bus.display_on}), 32'({10'(gh), 10'(gv), gd}));
        end
    endtask

    task automatic wait_pos(input int v, input int h, input string tag);
        int k = 0;
        while (!(gv == v && gh == h) && k < 2 * FRAME) begin
            cyc();
            k++;
        end
        check(tag, 32'(gv == v && gh == h), 32'd1);
    endtask

    // Runs from just after reset release until full lock plus a checked frame.
    task automatic lock_seq();
        int k;
        repeat (HL + LK * HT - 1) cyc();
        check("hlock_before", 32'(bus.h_locked), 32'd0);
        cyc();
        check("hlock_rise", 32'(bus.h_locked), 32'd1);
        k = VS * HT + 3 + FRAME - 1 - n;
        repeat (k) cyc();
        check("vlock_before", 32'(bus.v_locked), 32'd0);
        cyc();
        check("vlock_rise", 32'(bus.v_locked), 32'd1);
        gen_chk = 1'b1;
        repeat (FRAME + 200) cyc();
        gen_chk = 1'b0;
    endtask

    initial begin
        int r_line, r_pix, hold, k;
        gen_reset();
        model_reset();
        force_h = 1'b0; force_v = 1'b0; gen_chk = 1'b0;
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out", outs(), 32'd0);
        check("reset_hper", 32'(dut.hper_q), 32'd1023);
        rst = 1'b0;

        lock_seq();

        // one line shortened by a pixel
        r_line = $urandom_range(2, 10);
        r_pix  = $urandom_range(5, 30);
        wait_pos(r_line, r_pix, "wait_short_line");
        skip_pix = 1'b1;
        wait_pos(r_line, HL, "wait_bad_hfall");
        check("short_h_drop", 32'({bus.h_locked, bus.v_locked}), 32'b01);
        cyc();
        check("short_v_drop", 32'({bus.h_locked, bus.v_locked, bus.display_on}), 32'b000);
        repeat (2 * FRAME) cyc();
        check("relock_hv", 32'({bus.h_locked, bus.v_locked}), 32'b11);
        gen_chk = 1'b1;
        repeat (FRAME) cyc();
        gen_chk = 1'b0;

        // one frame shortened by a line
        r_line = $urandom_range(2, 12);
        wait_pos(r_line, 10, "wait_short_frame");
        skip_line = 1'b1;
        wait_pos(VS + 1, 10, "wait_bad_vfall");
        check("short_frame", 32'({bus.h_locked, bus.v_locked}), 32'b10);
        cyc();
        wait_pos(VS + 1, 10, "wait_good_vfall");
        check("restore_v", 32'({bus.h_locked, bus.v_locked}), 32'b11);

        // HSync and VSync falling together
        wait_pos(0, 5, "wait_coincide");
        force_v = 1'b1;
        k = 0;
        while (!(g_hs == 1'b0 && g_vs == 1'b0) && k < 2 * FRAME) begin
            cyc();
            k++;
        end
        check("coincide_found", 32'(g_hs == 1'b0 && g_vs == 1'b0), 32'd1);
        force_v = 1'b0;
        cyc();
        cyc();
        check("co_pos", 32'({bus.hpos, bus.vpos}), 32'({10'(HL), 10'(VL)}));
        check("co_vlines", 32'(dut.vlines_q), 32'd1);
        repeat (FRAME) cyc();
        check("co_vkeep", 32'({bus.h_locked, bus.v_locked}), 32'b11);

        // HSync stuck high
        wait_pos(3, 10, "wait_hold");
        force_h = 1'b1;
        hold = 1100 + $urandom_range(0, 40);
        repeat (hold) cyc();
        check("hold_unlock", 32'({bus.h_locked, bus.v_locked}), 32'b00);
        check("hold_hpos", 32'(bus.hpos), 32'(gh));
        force_h = 1'b0;
        repeat (3 * FRAME) cyc();
        check("hold_relock", 32'({bus.h_locked, bus.v_locked}), 32'b11);

        // asynchronous reset mid-frame while locked
        r_line = $urandom_range(3, 10);
        r_pix  = $urandom_range(5, 30);
        wait_pos(r_line, r_pix, "wait_rst");
        check("pre_rst_lock", 32'({bus.h_locked, bus.v_locked}), 32'b11);
        #2 rst = 1'b1;
        #1;
        check("arst_out", outs(), 32'd0);
        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        gen_reset();
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        lock_seq();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
